// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl
//
// Sequencer for an N x N output-stationary systolic array. A start request
// clears every PE accumulator for one cycle. The block then runs the array for
// K+2N-1 enabled cycles and emits a one-cycle done pulse. While running it
// drives a skewed valid/index pair per boundary lane, so row i and column i
// receive operand k at run time t = k + i.
//
// Ports
//   clk         : rising-edge clock
//   reset       : asynchronous, active-low reset
//   start       : job request, sampled only while idle
//   stall       : operand source not ready; freezes the run counter
//   busy        : high from the clear cycle through the done cycle
//   done        : one-cycle completion pulse
//   pe_clr      : array-wide accumulator clear
//   pe_en       : array-wide clock enable
//   lane_valid  : bit i set when lane i carries a real operand
//   lane_k      : field i = operand index for lane i (zero when invalid)
// ---------------------------------------------------------------------------
module systolic_seq_ctrl #(
   parameter int N  = 4,
   parameter int K  = 4,
   parameter int KW = 8,
   parameter int CW = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   output logic              busy,
   output logic              done,
   output logic              pe_clr,
   output logic              pe_en,
   output logic [N-1:0]      lane_valid,
   output logic [N*KW-1:0]   lane_k
);

   // Value of t in the final RUN cycle; the far-corner PE takes its last
   // product on the edge that ends this cycle.
   localparam logic [CW-1:0] T_LAST = CW'(K + 2*N - 2);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_RUN   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [CW-1:0]   t_q;
   logic [CW-1:0]   t_d;
   logic            run_s;

   // State and run-counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         t_q     <= {CW{1'b0}};
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
      end
   end

   // Next-state logic and array control outputs.
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      busy    = 1'b0;
      done    = 1'b0;
      pe_clr  = 1'b0;
      pe_en   = 1'b0;
      run_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
            end else begin
               state_d = S_IDLE;
            end
            t_d = {CW{1'b0}};
         end
         S_CLEAR: begin
            busy    = 1'b1;
            pe_clr  = 1'b1;
            t_d     = {CW{1'b0}};
            state_d = S_RUN;
         end
         S_RUN: begin
            busy  = 1'b1;
            run_s = 1'b1;
            if (!stall) begin
               // The array advances only on unstalled cycles, so t counts
               // enabled edges rather than wall-clock cycles.
               pe_en = 1'b1;
               t_d   = t_q + CW'(1);
               if (t_q == T_LAST) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RUN;
               end
            end else begin
               t_d     = t_q;
               state_d = S_RUN;
            end
         end
         S_DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            t_d     = {CW{1'b0}};
            state_d = S_IDLE;
         end
         default: begin
            t_d     = {CW{1'b0}};
            state_d = S_IDLE;
         end
      endcase
   end

   // Per-lane skew decode: lane i is delayed by i cycles. The subtraction is
   // one bit wider than t, so its top bit flags t < i without wrapping.
   for (genvar g = 0; g < N; g++) begin : g_lane
      logic [CW:0] diff_s;
      logic        valid_s;

      assign diff_s  = {1'b0, t_q} - (CW+1)'(g);
      assign valid_s = run_s && (diff_s[CW] == 1'b0) && (diff_s < (CW+1)'(K));

      assign lane_valid[g]        = valid_s;
      assign lane_k[g*KW +: KW]   = valid_s ? KW'(diff_s) : {KW{1'b0}};
   end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for systolic_seq_ctrl. The stimulus process issues jobs and
// pushes each job's operands and expected matrix product into a queue. The
// monitor process pops a job when it is accepted, predicts the control and
// lane outputs from an elapsed-cycle timeline, feeds the DUT lanes into a
// behavioural N x N array, and compares the accumulated result with the
// plain matrix product when the job completes.
// ---------------------------------------------------------------------------
module tb_systolic_seq_ctrl;

   localparam int N  = 4;
   localparam int K  = 4;
   localparam int KW = 8;
   localparam int CW = 8;
   localparam int L  = K + 2*N - 1;   // enabled cycles per job

   logic            clk;
   logic            reset;
   logic            start;
   logic            stall;
   logic            busy;
   logic            done;
   logic            pe_clr;
   logic            pe_en;
   logic [N-1:0]    lane_valid;
   logic [N*KW-1:0] lane_k;

   systolic_seq_ctrl #(.N(N), .K(K), .KW(KW), .CW(CW)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .stall      (stall),
      .busy       (busy),
      .done       (done),
      .pe_clr     (pe_clr),
      .pe_en      (pe_en),
      .lane_valid (lane_valid),
      .lane_k     (lane_k)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      int a[N][K];
      int b[K][N];
      int c[N][N];
   } job_t;

   job_t jobq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: cycle %0d got 0x%0h expected 0x%0h", name, cyc, act, exp);
      end
   endtask

   // ---------------- monitor / reference model ----------------
   job_t cur;
   bit   active = 1'b0;
   int   since;
   int   en_cnt;
   int   acc[N][N];
   int   a_reg[N][N];
   int   b_reg[N][N];
   int   na[N][N];
   int   nb[N][N];
   int   west[N];
   int   north[N];

   always @(negedge clk) begin
      logic            busy_e, done_e, clr_e, en_e, in_run;
      logic [N-1:0]    v_e;
      logic [N*KW-1:0] k_e;
      int              tt, kk, ain, bin;

      if (reset !== 1'b1) begin
         active = 1'b0;
         check("reset_outputs", {busy, done, pe_clr, pe_en, lane_valid, lane_k}, 64'd0);
      end else begin
         if (!active && jobq.size() > 0 && start === 1'b1) begin
            cur    = jobq.pop_front();
            active = 1'b1;
            since  = 0;
            en_cnt = 0;
         end

         busy_e = active && since >= 1;
         clr_e  = active && since == 1;
         in_run = active && since >= 2 && en_cnt < L;
         en_e   = in_run && !stall;
         done_e = active && since >= 2 && en_cnt == L;

         v_e = '0;
         k_e = '0;
         if (in_run) begin
            for (int i = 0; i < N; i++) begin
               tt = en_cnt - i;
               if (tt >= 0 && tt < K) begin
                  v_e[i]          = 1'b1;
                  k_e[i*KW +: KW] = KW'(tt);
               end
            end
         end

         check("ctrl", {busy, done, pe_clr, pe_en}, {busy_e, done_e, clr_e, en_e});
         check("lanes", {lane_valid, lane_k}, {v_e, k_e});

         if (done_e) begin
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++)
                  check($sformatf("acc[%0d][%0d]", i, j), acc[i][j], cur.c[i][j]);
         end

         // Behavioural array driven by the DUT's own control and lanes.
         if (pe_clr === 1'b1) begin
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) begin
                  acc[i][j]   = 0;
                  a_reg[i][j] = 0;
                  b_reg[i][j] = 0;
               end
         end
         if (pe_en === 1'b1) begin
            for (int i = 0; i < N; i++) begin
               kk       = int'(lane_k[i*KW +: KW]);
               west[i]  = (lane_valid[i] === 1'b1 && kk < K) ? cur.a[i][kk] : 0;
               north[i] = (lane_valid[i] === 1'b1 && kk < K) ? cur.b[kk][i] : 0;
            end
            for (int i = 0; i < N; i++)
               for (int j = 0; j < N; j++) begin
                  ain = (j == 0) ? west[i]  : a_reg[i][j-1];
                  bin = (i == 0) ? north[j] : b_reg[i-1][j];
                  acc[i][j] += ain * bin;
                  na[i][j]   = ain;
                  nb[i][j]   = bin;
               end
            a_reg = na;
            b_reg = nb;
         end

         if (in_run && !stall) en_cnt++;
         if (done_e) active = 1'b0;
         else if (active) since++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         start = 1'b0;
         stall = 1'($urandom_range(0, 1));
      end
   endtask

   function automatic job_t make_job(input int mode);
      job_t j;
      for (int i = 0; i < N; i++)
         for (int k = 0; k < K; k++) begin
            j.a[i][k] = (mode == 0) ? ((i == k) ? 2 : 1) : int'($urandom_range(0, 15));
            j.b[k][i] = (mode == 0) ? ((i == k) ? 2 : 1) : int'($urandom_range(0, 15));
         end
      for (int i = 0; i < N; i++)
         for (int c = 0; c < N; c++) begin
            j.c[i][c] = 0;
            for (int k = 0; k < K; k++) j.c[i][c] += j.a[i][k] * j.b[k][c];
         end
      return j;
   endfunction

   // mode 0: identity-plus-ones, 1: random, 2: stall t=5 x3,
   // 3: stall across the final run cycle x2, 4: random stalls and stray starts
   task automatic do_job(input int mode, output int lat);
      int c0;
      int d;
      int guard;
      job_t j;
      j = make_job(mode);
      @(posedge clk); #1;
      jobq.push_back(j);
      start = 1'b1;
      stall = (mode == 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      c0    = cyc;
      lat   = -1;
      guard = 0;
      forever begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = cyc - c0;
            break;
         end
         guard++;
         if (guard > 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: no done within 200 cycles of start at cycle %0d", c0);
            break;
         end
         @(posedge clk); #1;
         d     = cyc - c0;
         start = (mode == 4) ? ($urandom_range(0, 3) == 0) : 1'b0;
         case (mode)
            2:       stall = (d >= 7 && d <= 9);
            3:       stall = (d >= 12 && d <= 13);
            4:       stall = ($urandom_range(0, 3) == 0);
            default: stall = 1'b0;
         endcase
      end
   endtask

   initial begin
      int lat;
      reset = 1'b0;
      start = 1'b1;
      stall = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b1;
      start = 1'b0;
      stall = 1'b0;
      idle(3);

      do_job(0, lat);
      check("latency_nostall", lat, K + 2*N + 1);
      do_job(1, lat);
      check("latency_back2back", lat, K + 2*N + 1);
      do_job(2, lat);
      check("latency_stall3", lat, K + 2*N + 4);
      do_job(3, lat);
      check("latency_final_stall", lat, K + 2*N + 3);
      idle(2);

      // Abandon a job mid-run with reset; no done may follow.
      @(posedge clk); #1;
      jobq.push_back(make_job(1));
      start = 1'b1;
      stall = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      idle(4);

      do_job(0, lat);
      check("latency_after_reset", lat, K + 2*N + 1);

      for (int n = 0; n < 20; n++) begin
         do_job(4, lat);
         idle($urandom_range(0, 3));
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/systolic_seq_ctrl.md
# systolic_seq_ctrl

Sequencer for an N×N output-stationary systolic array built from P_Element tiles. On a start pulse it clears every PE accumulator, then drives one skewed valid/index pair per boundary lane so the operand fetch logic feeds row i and column i delayed by i cycles. It runs the array until the far-corner PE has absorbed its last operand product, then pulses done. It sits between the host command interface and the array's edge operand muxes, and also drives the array-wide clear and enable.

## Interface
- N, 4, array dimension: number of boundary rows and columns; N ≥ 1.
- K, 4, inner (reduction) dimension: operands per lane per job; K ≥ 1.
- KW, 8, width of each lane index field; 2^KW ≥ K.
- CW, 8, run-counter width; 2^CW ≥ K+2N-1.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  job request; sampled only in IDLE.
- stall  input  1  operand source not ready; freezes the run.
- busy  output  1  high from the CLEAR state through the DONE state inclusive.
- done  output  1  one-cycle pulse marking job completion.
- pe_clr  output  1  active-high accumulator clear to every PE.
- pe_en  output  1  array clock-enable; PEs and edge registers advance only when high.
- lane_valid  output  N  bit i: lane i (row i west input and column i north input) carries a real operand this cycle.
- lane_k  output  N*KW  field i, bits [i*KW +: KW]: operand index k for lane i; zero when lane_valid[i]=0.

## Operation
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: all outputs 0. If start=1, next state is CLEAR.
- CLEAR: lasts exactly one cycle. pe_clr=1, busy=1, pe_en=0. Run counter t is loaded with 0. Next state is RUN.
- RUN: busy=1.
  - If stall=0: pe_en=1 and t increments.
  - If stall=1: pe_en=0, t holds, and lane_valid/lane_k hold their decoded values. The edge muxes ignore them because pe_en is low.
  - The cycle with t = K+2N-2 and stall=0 is the last RUN cycle. Next state is DONE.
- Lane decode (combinational from state and t, RUN only): lane_valid[i] = (t ≥ i) && (t − i < K); lane_k[i] = t − i when valid, else 0.
- When lane i is invalid, the edge mux drives 0 into the array, so stray products contribute nothing.
- Skew rationale: operand k reaches PE(i,j) from both directions at t = k+i+j. The last product lands in PE(N−1,N−1) at t = K+2N−3 and is accumulated on the following edge. The RUN length is therefore K+2N−1 enabled cycles.
- DONE: lasts one cycle. done=1, busy=1, pe_en=0, lanes 0. Next state is IDLE. PE outputs remain valid until the next CLEAR.
- start outside IDLE is ignored; there is no queueing.
- stall outside RUN is ignored.
- Arithmetic: t is unsigned CW bits. The compare t − i is done at CW+1 bits so it never wraps. lane_k is truncated to KW bits, which is lossless given the parameter constraint.

## Timing
- Reset (reset=0, asynchronous): state goes to IDLE, t=0, and every output is 0 immediately, with no clock needed.
- Reset mid-job: the job is abandoned with no done pulse. After release, the block waits in IDLE for a fresh start.
- Latency with no stalls, for start sampled at edge E0:
  - CLEAR occupies cycle 1.
  - RUN occupies cycles 2 .. K+2N.
  - done is high in cycle K+2N+1.
  - start is accepted again from cycle K+2N+2.
- Each stall cycle adds exactly one cycle to the done latency.
- Simultaneous stall=1 on the final RUN cycle: the block stays in RUN with t held, and leaves once stall drops.
- Job length per K+2N+1 busy cycles: N²·K MACs, with no overlap between jobs.

## Test plan
- Reset: hold reset=0 with start=1 and stall=1 → every output 0 for the whole hold; the block stays in IDLE after release until a new start.
- N=4, K=4, single start at cycle 0, stall=0 → pe_clr high only in cycle 1; pe_en high in cycles 2–12; done only in cycle 13; busy high in cycles 1–13.
- Same job, lane decode → lane 0 valid at t=0..3 with k=0,1,2,3; lane 3 valid at t=3..6 with k=0..3; all lanes 0 at t=7..10.
- Stall: stall=1 for 3 cycles at t=5 → t holds at 5, pe_en=0 for 3 cycles, lane outputs frozen, done moves to cycle 16.
- start pulses during RUN and during DONE → ignored; exactly one done per accepted start.
- Integration: 4×4 array of P_Element tiles, A=B=identity-plus-ones pattern → after done, each PE out equals the software reference dot product; a second job gives fresh results with no carryover.
